// File: rtl/seg_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_pkg
// Purpose  : Shared types, constants and helpers for the 7-segment scan mux.
// Revision : 1.0
// ============================================================================
package seg_scan_pkg;

    localparam int         MAX_DIGITS = 8;
    localparam logic [6:0] SEG_BLANK  = 7'h7F;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    // Active-low anode vector with only bit idx pulled low; bits at or above n stay high.
    function automatic logic [MAX_DIGITS-1:0] onehot_low(input logic [2:0] idx, input int n);
        logic [MAX_DIGITS-1:0] v;
        v = '1;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < n && i == int'(idx)) begin
                v[i] = 1'b0;
            end
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_scan_if.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_if
// Purpose  : Digit-data and pin-side signal bundle of the 7-segment scan mux.
// Revision : 1.0
// ============================================================================
interface seg_scan_if #(
    parameter int N_DIGITS = 4,
    parameter int PWM_BITS = 4
);
    logic [7*N_DIGITS-1:0] seg_data;
    logic [N_DIGITS-1:0]   dp_in;
    logic [N_DIGITS-1:0]   enable_mask;
    logic [N_DIGITS-1:0]   blink_mask;
    logic                  blink_all;
    logic [PWM_BITS-1:0]   brightness;
    logic [N_DIGITS-1:0]   ANODE;
    logic [6:0]            SEG;
    logic                  DP;
    logic                  blink_phase;
    logic                  frame_start;

    modport master (
        output seg_data, dp_in, enable_mask, blink_mask, blink_all, brightness,
        input  ANODE, SEG, DP, blink_phase, frame_start
    );

    modport slave (
        input  seg_data, dp_in, enable_mask, blink_mask, blink_all, brightness,
        output ANODE, SEG, DP, blink_phase, frame_start
    );
endinterface
`default_nettype wire

// File: rtl/seg_scan_mux_blink.sv
`default_nettype none
// ============================================================================
// Module   : seg_blink_gen
// Purpose  : Free-running blink divider; phase toggles every HALF clocks.
// Revision : 1.0
// ============================================================================
module seg_blink_gen #(
    parameter int HALF = 25000000
) (
    input  wire logic MCLK,
    input  wire logic RESET_N,
    output logic      blink_phase
);
    localparam int               CNT_W  = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(HALF - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_phase;

    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_cnt   <= '0;
            r_phase <= 1'b1;
        end else if (r_cnt == c_last) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    assign blink_phase = r_phase;

endmodule
`default_nettype wire

// File: rtl/seg_scan_mux.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_mux
// Purpose  : N-digit common-anode 7-segment scanner with dead-time, PWM,
//            per-digit blink/enable and per-slot input snapshotting.
// Revision : 1.0
// ============================================================================
module seg_scan_mux
    import seg_scan_pkg::*;
#(
    parameter int N_DIGITS   = 4,
    parameter int SCAN_DIV   = 65536,
    parameter int BLANK_CYC  = 64,
    parameter int BLINK_HALF = 25000000,
    parameter int PWM_BITS   = 4
) (
    input  wire logic  MCLK,
    input  wire logic  RESET_N,
    seg_scan_if.slave  bus
);
    if (N_DIGITS < 1 || N_DIGITS > MAX_DIGITS) begin : g_chk_digits
        $error("seg_scan_mux: N_DIGITS must be in 1..8");
    end
    if (BLANK_CYC < 1) begin : g_chk_blank
        $error("seg_scan_mux: BLANK_CYC must be at least 1");
    end
    if (PWM_BITS < 1 || SCAN_DIV <= BLANK_CYC + (1 << PWM_BITS)) begin : g_chk_scan
        $error("seg_scan_mux: SCAN_DIV must exceed BLANK_CYC + 2**PWM_BITS");
    end
    if (BLINK_HALF < 1) begin : g_chk_blink
        $error("seg_scan_mux: BLINK_HALF must be at least 1");
    end

    localparam int                  SLOT_W       = $clog2(SCAN_DIV);
    localparam int                  DIG_W        = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [SLOT_W-1:0]   c_blank_last = SLOT_W'(BLANK_CYC - 1);
    localparam logic [SLOT_W-1:0]   c_slot_last  = SLOT_W'(SCAN_DIV - 1);
    localparam logic [DIG_W-1:0]    c_dig_last   = DIG_W'(N_DIGITS - 1);
    localparam logic [PWM_BITS-1:0] c_pwm_full   = '1;

    scan_state_t           r_state;
    logic [SLOT_W-1:0]     r_slot_cnt;
    logic [DIG_W-1:0]      r_digit;
    logic [PWM_BITS-1:0]   r_pwm_cnt;
    logic [6:0]            r_snap_seg;
    logic                  r_snap_dp;
    logic                  r_snap_en;
    logic                  r_snap_blink;
    logic [PWM_BITS-1:0]   r_snap_bright;
    logic [N_DIGITS-1:0]   r_anode;
    logic [6:0]            r_seg;
    logic                  r_dp;
    logic                  r_frame_start;

    logic                  w_blink_phase;
    logic [6:0]            w_cur_seg;
    logic                  w_cur_dp;
    logic                  w_cur_en;
    logic                  w_cur_blink;
    logic                  w_lit;
    logic [MAX_DIGITS-1:0] w_anode_sel;
    logic                  w_unused;

    seg_blink_gen #(.HALF(BLINK_HALF)) u_blink (
        .MCLK        (MCLK),
        .RESET_N     (RESET_N),
        .blink_phase (w_blink_phase)
    );

    always_comb begin
        w_cur_seg   = SEG_BLANK;
        w_cur_dp    = 1'b0;
        w_cur_en    = 1'b0;
        w_cur_blink = 1'b0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (r_digit == DIG_W'(k)) begin
                w_cur_seg   = bus.seg_data[7*k +: 7];
                w_cur_dp    = bus.dp_in[k];
                w_cur_en    = bus.enable_mask[k];
                w_cur_blink = bus.blink_mask[k] | bus.blink_all;
            end
        end
    end

    // Visibility uses the live blink phase so a toggle lands mid-slot.
    assign w_lit = (r_state == SHOW) && r_snap_en
                && (!r_snap_blink || w_blink_phase)
                && ((r_snap_bright == c_pwm_full) || (r_pwm_cnt < r_snap_bright));

    assign w_anode_sel = onehot_low(3'(r_digit), N_DIGITS);
    assign w_unused    = &{1'b0, w_anode_sel};

    // Pins follow the scan state one register later; frame_start marks the state entry itself.
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state       <= BLANK;
            r_slot_cnt    <= '0;
            r_digit       <= '0;
            r_pwm_cnt     <= '0;
            r_snap_seg    <= SEG_BLANK;
            r_snap_dp     <= 1'b0;
            r_snap_en     <= 1'b0;
            r_snap_blink  <= 1'b0;
            r_snap_bright <= '0;
            r_anode       <= '1;
            r_seg         <= SEG_BLANK;
            r_dp          <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_slot_cnt    <= (r_slot_cnt == c_slot_last) ? '0 : r_slot_cnt + 1'b1;
            r_pwm_cnt     <= r_pwm_cnt + 1'b1;
            r_frame_start <= 1'b0;
            r_anode       <= w_lit ? w_anode_sel[N_DIGITS-1:0] : '1;
            r_seg         <= (r_state == SHOW) ? r_snap_seg : SEG_BLANK;
            r_dp          <= (r_state == SHOW) ? ~r_snap_dp : 1'b1;
            case (r_state)
                BLANK: begin
                    if (r_slot_cnt == c_blank_last) begin
                        r_snap_seg    <= w_cur_seg;
                        r_snap_dp     <= w_cur_dp;
                        r_snap_en     <= w_cur_en;
                        r_snap_blink  <= w_cur_blink;
                        r_snap_bright <= bus.brightness;
                        r_pwm_cnt     <= '0;
                        r_state       <= SHOW;
                    end
                end
                SHOW: begin
                    if (r_slot_cnt == c_slot_last) begin
                        r_state <= BLANK;
                        if (r_digit == c_dig_last) begin
                            r_digit       <= '0;
                            r_frame_start <= 1'b1;
                        end else begin
                            r_digit <= r_digit + 1'b1;
                        end
                    end
                end
                default: r_state <= BLANK;
            endcase
        end
    end

    assign bus.ANODE       = r_anode;
    assign bus.SEG         = r_seg;
    assign bus.DP          = r_dp;
    assign bus.blink_phase = w_blink_phase;
    assign bus.frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
- Parametrised time-multiplexed driver for N-digit common-anode 7-segment displays with decimal points.
- Adds, per digit:
  - a blanking dead-time between digit switches, to suppress ghosting;
  - PWM brightness control;
  - an individual blink mask and enable mask;
  - tear-free data snapshotting.
- Sits between the digit encoders (clock/alarm/mode logic) and the board pins; provides the frame_start strobe.

Parameters:
- N_DIGITS, 4: number of digits; legal range 1..8, need not be a power of 2.
- SCAN_DIV, 65536: MCLK cycles per digit slot (BLANK + SHOW); must be greater than BLANK_CYC + 2^PWM_BITS.
- BLANK_CYC, 64: MCLK cycles with all anodes off at the start of each slot; must be ≥1.
- BLINK_HALF, 25000000: MCLK cycles per blink half-period.
- PWM_BITS, 4: brightness resolution.

Ports:
- MCLK  in  1  system clock.
- RESET_N  in  1  asynchronous, active-low reset.
- seg_data  in  7*N_DIGITS  active-low segment patterns; digit k occupies bits [7k+6:7k].
- dp_in  in  N_DIGITS  active-high decimal point, one per digit.
- enable_mask  in  N_DIGITS  1 = digit lit; 0 = slot consumed but anode held off.
- blink_mask  in  N_DIGITS  1 = digit blinks.
- blink_all  in  1  forces every enabled digit to blink (alarm ringing).
- brightness  in  PWM_BITS  duty select; 0 = dark, all-ones = 100%.
- ANODE  out  N_DIGITS  active-low anode select; digit k drives ANODE[k].
- SEG  out  7  active-low segments.
- DP  out  1  active-low decimal point.
- blink_phase  out  1  1 = visible half of the blink cycle.
- frame_start  out  1  one-cycle pulse.

Behaviour:
- Reset (asynchronous, RESET_N = 0), applied immediately including mid-slot:
  - ANODE all 1s, SEG = 7'h7F, DP = 1.
  - blink_phase = 1, frame_start = 0.
  - state = BLANK, digit index = 0, slot counter = 0, blink counter = 0.
- All outputs are registered.
- State machine, per slot:
  - BLANK: lasts BLANK_CYC cycles. ANODE all 1s, SEG = 7'h7F, DP = 1.
  - On the last BLANK cycle, snapshot the current digit's seg_data slice, dp_in bit, enable bit, effective blink bit and brightness; then go to SHOW.
  - SHOW: lasts SCAN_DIV − BLANK_CYC cycles. SEG and DP are driven from the snapshot for the whole of SHOW; input changes during SHOW have no effect until the next slot.
  - At the end of SHOW: digit index advances, wrapping from N_DIGITS−1 to 0 (e.g. 5→0 when N_DIGITS = 6); then go to BLANK.
  - With N_DIGITS = 1 the index stays 0 and the BLANK/SHOW alternation still occurs.
- frame_start: high for exactly the first MCLK cycle of the BLANK that begins digit 0's slot. After reset it first asserts SCAN_DIV·N_DIGITS cycles after RESET_N deasserts; the post-reset slot does not pulse.
- PWM:
  - pwm_cnt (PWM_BITS wide) resets to 0 on entry to SHOW and increments every cycle, wrapping.
  - Anode k is driven low in SHOW only when all of these hold: enable snapshot = 1; visibility = 1; (brightness snapshot = all-ones OR pwm_cnt < brightness snapshot).
  - Brightness 0 keeps the anode off for the entire slot.
- Blink:
  - Effective blink bit = blink_mask[k] OR blink_all.
  - Visibility = (effective blink bit = 0) OR blink_phase.
  - Visibility is evaluated every cycle, so a blink_phase toggle mid-SHOW takes effect on the next cycle.
  - blink_phase toggles when the blink counter reaches BLINK_HALF−1; the counter then returns to 0. The blink counter runs independently of the scan.
- Anode gating: when a digit's anode is gated off (disabled, invisible, or in the PWM off-phase), SEG stays at the snapshot value; only the anode gates.
- Counter widths: $clog2 of the respective limits; no overflow is possible for legal parameters.
- Parameter checks: illegal combinations stop elaboration with an error.

Decomposition:
- Package seg_scan_pkg contains:
  - SEG_BLANK = 7'h7F;
  - the state type {BLANK, SHOW};
  - the function onehot_low(idx, n), which returns the active-low anode vector.
- Sub-module seg_blink_gen (parameter HALF): a free-running divider producing blink_phase. It is reusable by other blinking UI blocks.

Test Plan (all scenarios use N_DIGITS=6, SCAN_DIV=16, BLANK_CYC=2, BLINK_HALF=200, PWM_BITS=2):
1. Reset sequencing:
   - Stimulus: hold RESET_N=0 for 5 cycles, then release.
   - Required: ANODE=6'h3F, SEG=7'h7F; first ANODE=6'b111110 appears on cycle 3 after release; frame_start first pulses at cycle 96.
2. Wrap and order:
   - Stimulus: seg_data digits 0..5 = 7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12; brightness=3; all enabled.
   - Required: anodes walk 0→5→0; each digit shows its own pattern for 14 cycles, preceded by 2 all-off cycles.
3. Snapshot:
   - Stimulus: change digit 2's slice mid-SHOW.
   - Required: SEG holds the old value until that slot ends; the new value appears on digit 2's next slot.
4. PWM:
   - Stimulus: brightness=1.
   - Required: anode low 1 of every 4 SHOW cycles.
   - Stimulus: brightness=0.
   - Required: ANODE stays 6'h3F continuously.
5. Blink:
   - Stimulus: blink_mask=6'b000100.
   - Required: digit 2's anode is suppressed for 200-cycle windows while blink_phase=0; the other digits are unaffected.
   - Stimulus: blink_all=1.
   - Required: all digits are suppressed together.
6. Enable and async reset:
   - Stimulus: enable_mask=6'b011111.
   - Required: slot 5 keeps its timing with ANODE[5] held at 1.
   - Stimulus: assert RESET_N low mid-SHOW.
   - Required: outputs return to their reset values in the same cycle, without waiting for an MCLK edge.
